frame_gen_seq: RTL
==================

Name: frame_gen_seq

Overview:
- Parametrised, runtime-configurable Ethernet test-frame generator for the delay tester.
- Drives the MAC TX byte interface with configurable addresses, EtherType, frame length, inter-frame gap and burst count.
- Stamps each frame with a 32-bit sequence number and a 32-bit timestamp captured at the MAC ack cycle, so the receive side can measure one-way delay and loss.

Parameters:
- MIN_FRAME_LEN, 60: lower length clamp in bytes, excluding CRC.
- MAX_FRAME_LEN, 9014: upper length clamp in bytes.
- STD_MAX_LEN, 1514: lengths above this assert conf_tx_jumbo_en.
- MIN_GAP, 12: minimum idle cycles between frames.
- LEN_WIDTH, 14: width of the cfg_frame_len bus.
- GAP_WIDTH, 16: width of the cfg_gap bus.
- CNT_WIDTH, 16: width of cfg_count and frames_sent.

Ports:
- tx_clk  in  1  TX clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a burst from IDLE.
- stop  in  1  level or pulse; finish current frame, then IDLE.
- cfg_dst_mac  in  48  destination MAC.
- cfg_src_mac  in  48  source MAC.
- cfg_eth_type  in  16  EtherType.
- cfg_frame_len  in  LEN_WIDTH  frame length in bytes, excluding CRC.
- cfg_gap  in  GAP_WIDTH  idle cycles between frames.
- cfg_count  in  CNT_WIDTH  frames per burst; 0 means continuous.
- timestamp  in  32  free-running time counter.
- conf_tx_en  out  1  MAC TX enable.
- conf_tx_jumbo_en  out  1  MAC jumbo enable.
- conf_tx_no_gen_crc  out  1  always 0; MAC appends the FCS.
- mac_tx_data  out  8  TX byte.
- mac_tx_dvld  out  1  TX data valid.
- mac_tx_ack  in  1  MAC accepts first byte.
- busy  out  1  high in any state other than IDLE.
- frames_sent  out  CNT_WIDTH  frames completed in the current burst.

Behaviour:
- Reset is synchronous. At reset all outputs are 0, state = IDLE, seq = 0, frames_sent = 0.
- conf_tx_en goes to 1 on the first cycle after reset deasserts and stays high.
- All outputs are registered.
- States are IDLE, LOAD, WAIT_ACK, SEND, GAP.
- IDLE:
  - dvld = 0, data = 0.
  - start=1 → LOAD. Also: frames_sent ← 0, seq ← 0.
  - start is ignored in every state except IDLE.
- LOAD (1 cycle):
  - Latch all cfg_* inputs.
  - len ← clamp(cfg_frame_len, MIN_FRAME_LEN, MAX_FRAME_LEN).
  - gap ← max(cfg_gap, MIN_GAP).
  - conf_tx_jumbo_en ← (len > STD_MAX_LEN).
  - → WAIT_ACK.
  - cfg_* changes after LOAD have no effect until the next burst.
- WAIT_ACK:
  - dvld = 1; data = byte 0 (dst[47:40]), held with no timeout until ack.
  - mac_tx_ack is sampled only in WAIT_ACK; ack in any other state is ignored.
  - On the cycle ack=1: byte 0 is on the bus, ts_latch ← timestamp, → SEND with idx=1.
- SEND:
  - Byte idx is presented in cycle ack+idx; one byte per cycle; no backpressure.
  - Byte map, big-endian:
    - 0–5: dst MAC.
    - 6–11: src MAC.
    - 12–13: EtherType.
    - 14–17: seq.
    - 18–21: ts_latch.
    - 22..len-1: idx[7:0].
  - After byte len-1 (cycle ack+len-1), dvld = 0 from cycle ack+len onward.
  - At the same time: seq ← seq+1 (wraps at 2^32), frames_sent ← frames_sent+1 (wraps at 2^CNT_WIDTH).
- End of frame:
  - If (cfg_count≠0 and updated frames_sent == cfg_count) or stop has been seen since the frame began → IDLE.
  - Otherwise → GAP.
- GAP:
  - dvld = 0 for exactly gap cycles, then → WAIT_ACK with the next seq.
  - stop during GAP → IDLE on the next cycle.
- stop in WAIT_ACK:
  - Before ack: the frame is still sent once ack arrives (dvld is never withdrawn); then IDLE.
- Simultaneous start and stop in IDLE: start wins; the burst sends exactly one frame.
- Reset mid-frame: dvld = 0 on the next cycle, with no partial-frame completion.
- busy = (state ≠ IDLE).

Test Plan:
1. Reset, then start with len=60, gap=12, count=1; ack held 3 cycles after dvld rises.
   - dvld high exactly 3+60 cycles.
   - Bytes 14–17 = 00000000; bytes 18–21 = timestamp value in the ack cycle.
   - Return to IDLE; frames_sent=1.
2. len=40, count=3, gap=20; ack immediate each frame.
   - Each frame is 60 bytes; seq = 0, 1, 2.
   - Exactly 20 dvld-low cycles between frames; busy drops after frame 3.
3. len=2000, count=1.
   - conf_tx_jumbo_en=1; 2000 bytes sent.
   - Byte 1999 = 0xCF; byte 22 = 0x16.
4. count=0, gap=5.
   - Gap is clamped to 12.
   - Assert stop mid-frame 4 → frame 4 completes; IDLE; frames_sent=4.
5. Assert reset at byte 30 of a 100-byte frame.
   - Next cycle: dvld=0, data=0, busy=0.
   - A fresh start after reset sends seq=0.
6. Pulse ack during GAP and IDLE → no state change and no dvld; start pulsed during SEND → ignored.

Source files
------------

// File: rtl/frame_gen_seq_if.sv
// MAC TX byte interface between the frame generator (master) and the MAC (slave).
// Bytes and enables flow to the MAC; the single ack flows back once per frame.
interface frame_gen_seq_if;
    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_ack;
    logic       conf_tx_en;
    logic       conf_tx_jumbo_en;
    logic       conf_tx_no_gen_crc;

    modport master (
        output mac_tx_data, mac_tx_dvld, conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc,
        input  mac_tx_ack
    );

    modport slave (
        input  mac_tx_data, mac_tx_dvld, conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc,
        output mac_tx_ack
    );
endinterface

// File: rtl/frame_gen_seq.sv
// Ethernet test-frame generator: bursts of sequence/timestamp-stamped frames, registered outputs.
// Byte 0 is held until MAC ack, then one byte per cycle with no backpressure; gap idles between frames.
module frame_gen_seq #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int MAX_FRAME_LEN = 9014,
    parameter int STD_MAX_LEN   = 1514,
    parameter int MIN_GAP       = 12,
    parameter int LEN_WIDTH     = 14,
    parameter int GAP_WIDTH     = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 tx_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [47:0]          cfg_dst_mac,
    input  logic [47:0]          cfg_src_mac,
    input  logic [15:0]          cfg_eth_type,
    input  logic [LEN_WIDTH-1:0] cfg_frame_len,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic [31:0]          timestamp,
    frame_gen_seq_if.master      mac,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_sent
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, SEND, GAP} state_t;

    state_t               state;
    logic [47:0]          dst_q;
    logic [47:0]          src_q;
    logic [15:0]          type_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] idx;
    logic [GAP_WIDTH-1:0] gap_q;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [CNT_WIDTH-1:0] count_q;
    logic [31:0]          seq;
    logic [31:0]          ts_latch;
    logic                 stop_seen;

    logic [LEN_WIDTH-1:0] len_clamped;
    logic [GAP_WIDTH-1:0] gap_clamped;
    logic [CNT_WIDTH-1:0] sent_next;
    logic                 last_byte;
    logic                 burst_done;

    always_comb begin
        len_clamped = cfg_frame_len;
        if (cfg_frame_len < LEN_WIDTH'(MIN_FRAME_LEN)) begin
            len_clamped = LEN_WIDTH'(MIN_FRAME_LEN);
        end else if (cfg_frame_len > LEN_WIDTH'(MAX_FRAME_LEN)) begin
            len_clamped = LEN_WIDTH'(MAX_FRAME_LEN);
        end
        gap_clamped = (cfg_gap < GAP_WIDTH'(MIN_GAP)) ? GAP_WIDTH'(MIN_GAP) : cfg_gap;
    end

    assign sent_next  = frames_sent + CNT_WIDTH'(1);
    assign last_byte  = (idx == len_q - LEN_WIDTH'(1));
    // A stop arriving on the final byte still ends the burst after this frame.
    assign burst_done = ((count_q != '0) && (sent_next == count_q)) || stop_seen || stop;

    // Header occupies bytes 0..21 big-endian; the payload byte is the low byte of its index.
    function automatic logic [7:0] frame_byte(input logic [LEN_WIDTH-1:0] i);
        logic [175:0] hdr;
        logic [175:0] sh;
        hdr = {dst_q, src_q, type_q, seq, ts_latch};
        if (i < LEN_WIDTH'(22)) begin
            sh = hdr >> (8 * (21 - int'(i)));
            return sh[7:0];
        end
        return i[7:0];
    endfunction

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state                  <= IDLE;
            busy                   <= 1'b0;
            frames_sent            <= '0;
            seq                    <= '0;
            ts_latch               <= '0;
            idx                    <= '0;
            gap_cnt                <= '0;
            stop_seen              <= 1'b0;
            dst_q                  <= '0;
            src_q                  <= '0;
            type_q                 <= '0;
            len_q                  <= '0;
            gap_q                  <= '0;
            count_q                <= '0;
            mac.mac_tx_data        <= '0;
            mac.mac_tx_dvld        <= 1'b0;
            mac.conf_tx_en         <= 1'b0;
            mac.conf_tx_jumbo_en   <= 1'b0;
            mac.conf_tx_no_gen_crc <= 1'b0;
        end else begin
            mac.conf_tx_en         <= 1'b1;
            mac.conf_tx_no_gen_crc <= 1'b0;
            case (state)
                IDLE: begin
                    mac.mac_tx_dvld <= 1'b0;
                    mac.mac_tx_data <= '0;
                    if (start) begin
                        state       <= LOAD;
                        busy        <= 1'b1;
                        frames_sent <= '0;
                        seq         <= '0;
                        stop_seen   <= stop;
                    end
                end
                LOAD: begin
                    dst_q                <= cfg_dst_mac;
                    src_q                <= cfg_src_mac;
                    type_q               <= cfg_eth_type;
                    len_q                <= len_clamped;
                    gap_q                <= gap_clamped;
                    count_q              <= cfg_count;
                    mac.conf_tx_jumbo_en <= (len_clamped > LEN_WIDTH'(STD_MAX_LEN));
                    if (stop) stop_seen <= 1'b1;
                    mac.mac_tx_dvld      <= 1'b1;
                    mac.mac_tx_data      <= cfg_dst_mac[47:40];
                    state                <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (stop) stop_seen <= 1'b1;
                    if (mac.mac_tx_ack) begin
                        ts_latch        <= timestamp;
                        idx             <= LEN_WIDTH'(1);
                        mac.mac_tx_data <= frame_byte(LEN_WIDTH'(1));
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (last_byte) begin
                        mac.mac_tx_dvld <= 1'b0;
                        mac.mac_tx_data <= '0;
                        seq             <= seq + 32'd1;
                        frames_sent     <= sent_next;
                        if (burst_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= gap_q - GAP_WIDTH'(1);
                        end
                    end else begin
                        if (stop) stop_seen <= 1'b1;
                        idx             <= idx + LEN_WIDTH'(1);
                        mac.mac_tx_data <= frame_byte(idx + LEN_WIDTH'(1));
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state           <= WAIT_ACK;
                        mac.mac_tx_dvld <= 1'b1;
                        mac.mac_tx_data <= dst_q[47:40];
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    mac.mac_tx_dvld <= 1'b0;
                    mac.mac_tx_data <= '0;
                end
            endcase
        end
    end

endmodule
